rd_buffer: RTL and testbench
============================

RD_BUFFER -- requirements
Module: rd_buffer

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 128, AXI/user data width; legal values 64, 128, 256.
REQ-003 SHALL have parameter CMD_DEPTH, default 16, command FIFO entries (power of 2).
REQ-004 SHALL have parameter DATA_DEPTH, default 512, data FIFO entries (power of 2, ≥256).
REQ-005 SHALL have ports in this order:
- axi_clk  in  1  single clock; one clock; reset is synchronous and active-high.
- axi_rst  in  1  synchronous, active-high reset.
- rd_req_en  in  1  user read command strobe.
- rd_addr_in  in  AXI_ADDR_WIDTH  burst start address.
- rd_burst_len  in  8  AXI ARLEN (beats−1).
- axi_ar_req_en  out  1  AR valid toward read master.
- axi_ar_ready  in  1  AR accept.
- axi_ar_addr  out  AXI_ADDR_WIDTH  AR address.
- axi_ar_burst_len  out  8  AR length.
- axi_r_valid  in  1  R beat valid.
- axi_r_ready  out  1  R beat accept.
- axi_r_data  in  AXI_DATA_WIDTH  R data.
- axi_r_last  in  1  R last beat.
- rd_data_out  out  AXI_DATA_WIDTH  user data.
- rd_data_valid  out  1  user data valid.
- rd_data_last  out  1  last beat of burst.
- rd_data_ready  in  1  user accept.
- err_rcmd_fifo  out  1  command dropped pulse.
- err_rdata_fifo  out  1  R beat dropped pulse.
- err_rlast  out  1  burst length mismatch pulse.

Function
REQ-006 SHALL write {rd_burst_len, rd_addr_in} into the command FIFO at the edge where rd_req_en=1 and the FIFO is not full; the entry becomes visible (not empty) the following cycle.
REQ-007 SHALL drop rd_req_en when the command FIFO is full and pulse err_rcmd_fifo high for exactly one cycle, on the cycle after that edge.
REQ-008 SHALL implement a one-hot FSM: RD_IDLE=4'b0001, RD_REQ=4'b0010, RD_DATA=4'b0100, RD_END=4'b1000; illegal encodings SHALL return to RD_IDLE.
REQ-009 SHALL move RD_IDLE→RD_REQ when the command FIFO is non-empty and the data FIFO free entries ≥ head burst_len+1.
REQ-010 SHALL hold axi_ar_req_en high during RD_REQ, with axi_ar_addr/axi_ar_burst_len equal to the head command and stable until handshake.
REQ-011 SHALL, on axi_ar_req_en && axi_ar_ready, pop the command, latch burst_len, clear the beat counter, and enter RD_DATA.
REQ-012 SHALL drive axi_r_ready=1 throughout RD_DATA and 0 in all other states.
REQ-013 SHALL push {axi_r_last, axi_r_data} into the data FIFO on each axi_r_valid && axi_r_ready beat, and increment an 8-bit beat counter.
REQ-014 SHALL move RD_DATA→RD_END on an accepted beat with axi_r_last=1; RD_END→RD_IDLE unconditionally.
REQ-015 SHALL pulse err_rlast for one cycle if the accepted last beat index ≠ latched burst_len, or if a beat beyond index burst_len is accepted without last; termination SHALL still occur only on axi_r_last.
REQ-016 SHALL drop an R beat arriving while the data FIFO is full and pulse err_rdata_fifo for one cycle.
REQ-017 SHALL present the data FIFO head first-word-fall-through: rd_data_valid = not empty, rd_data_out/rd_data_last = head fields; pop on rd_data_valid && rd_data_ready.
REQ-018 SHALL allow a simultaneous push and pop on the same edge with an unchanged occupancy count, including when the FIFO is full.
REQ-019 SHALL give a minimum latency of two edges from rd_req_en to axi_ar_req_en high on an idle block.

Reset
REQ-020 SHALL, while axi_rst=1 at an edge, empty both FIFOs, set state RD_IDLE, and drive all outputs 0 (axi_ar_req_en, axi_ar_addr, axi_ar_burst_len, axi_r_ready, rd_data_valid, rd_data_out, rd_data_last, all err_*).
REQ-021 SHALL abandon any in-flight AR or R burst on reset mid-operation, with no stale beats delivered afterward.

Structure
REQ-022 SHALL place the state encodings and the command-word width (8+AXI_ADDR_WIDTH) in shared package axi_rw_pkg.
REQ-023 SHALL use one sub-module, sync_fifo (parameterised width/depth, FWFT, full/empty/count), instantiated for the command and data FIFOs.

Verification
REQ-024 SHALL cover this case: rd_req_en addr=0x1000, len=3; slave grants AR immediately and returns 4 beats D0..D3, last on D3 → AR at edge 2 with addr 0x1000/len 3; user sees D0..D3, rd_data_last only on D3; no errors.
REQ-025 SHALL cover this case: 17 back-to-back rd_req_en with axi_ar_ready=0 → 16 queued; err_rcmd_fifo pulses once; 17th dropped.
REQ-026 SHALL cover this case: len=7 slave asserts last on beat 5 → err_rlast one pulse; FSM returns to RD_IDLE; 6 beats delivered.
REQ-027 SHALL cover this case: rd_data_ready=0 with DATA_DEPTH=512 and eight len=255 commands → only two bursts issued; third AR withheld until ≥256 entries free.
REQ-028 SHALL cover this case: axi_rst asserted mid-burst after beat 2 of len=7 → next cycle all outputs 0, FIFOs empty; new command afterward completes cleanly.
REQ-029 SHALL cover this case: rd_data_ready toggling 1/0 during a len=15 burst with R beats every cycle → all 16 beats delivered in order, none dropped.

Source files
------------

// File: rtl/axi_rw_pkg.sv
// Shared definitions for the AXI read buffer: FSM encodings and command word sizing.
package axi_rw_pkg;

    localparam int unsigned BURST_LEN_W = 8;

    typedef enum logic [3:0] {
        RD_IDLE = 4'b0001,
        RD_REQ  = 4'b0010,
        RD_DATA = 4'b0100,
        RD_END  = 4'b1000
    } rd_state_e;

    // Command word is {burst_len, address}.
    function automatic int unsigned cmd_width(input int unsigned addr_w);
        return BURST_LEN_W + addr_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A push while full is accepted when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             rd_ok;
    logic             wr_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign rd_ok     = rd_en_i && !empty_o;
    assign wr_ok     = wr_en_i && (!full_o || rd_ok);

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rd_buffer.sv
// AXI read buffer: queues user read commands, issues AR bursts when the data
// FIFO can absorb a whole burst, and streams R beats to the user through a FIFO.
module rd_buffer
    import axi_rw_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 128,
    parameter int unsigned CMD_DEPTH      = 16,
    parameter int unsigned DATA_DEPTH     = 512
) (
    input  logic                      axi_clk,
    input  logic                      axi_rst,
    input  logic                      rd_req_en,
    input  logic [AXI_ADDR_WIDTH-1:0] rd_addr_in,
    input  logic [7:0]                rd_burst_len,
    output logic                      axi_ar_req_en,
    input  logic                      axi_ar_ready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
    output logic [7:0]                axi_ar_burst_len,
    input  logic                      axi_r_valid,
    output logic                      axi_r_ready,
    input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
    input  logic                      axi_r_last,
    output logic [AXI_DATA_WIDTH-1:0] rd_data_out,
    output logic                      rd_data_valid,
    output logic                      rd_data_last,
    input  logic                      rd_data_ready,
    output logic                      err_rcmd_fifo,
    output logic                      err_rdata_fifo,
    output logic                      err_rlast
);

    localparam int unsigned CMD_W   = cmd_width(AXI_ADDR_WIDTH);
    localparam int unsigned DFIFO_W = AXI_DATA_WIDTH + 1;
    localparam int unsigned CCNT_W  = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned DCNT_W  = $clog2(DATA_DEPTH) + 1;

    rd_state_e                 state_q;
    logic                      ar_req_en_q;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
    logic [7:0]                ar_len_q;
    logic [7:0]                len_q;
    logic [7:0]                beat_cnt_q;
    logic                      r_ready_q;
    logic                      err_rcmd_q;
    logic                      err_rdata_q;
    logic                      err_rlast_q;

    logic [CMD_W-1:0]          cmd_head;
    logic                      cmd_full;
    logic                      cmd_empty;
    logic [CCNT_W-1:0]         unused_cmd_count;
    logic                      cmd_pop;
    logic [DFIFO_W-1:0]        data_head;
    logic                      data_full;
    logic                      data_empty;
    logic [DCNT_W-1:0]         data_count;
    logic                      data_pop;
    logic                      beat_acc;
    logic [DCNT_W-1:0]         data_free;
    logic [DCNT_W-1:0]         data_need;

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk_i     (axi_clk),
        .rst_i     (axi_rst),
        .wr_en_i   (rd_req_en),
        .wr_data_i ({rd_burst_len, rd_addr_in}),
        .rd_en_i   (cmd_pop),
        .rd_data_o (cmd_head),
        .full_o    (cmd_full),
        .empty_o   (cmd_empty),
        .count_o   (unused_cmd_count)
    );

    sync_fifo #(.WIDTH(DFIFO_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk_i     (axi_clk),
        .rst_i     (axi_rst),
        .wr_en_i   (beat_acc),
        .wr_data_i ({axi_r_last, axi_r_data}),
        .rd_en_i   (data_pop),
        .rd_data_o (data_head),
        .full_o    (data_full),
        .empty_o   (data_empty),
        .count_o   (data_count)
    );

    assign cmd_pop   = (state_q == RD_REQ) && ar_req_en_q && axi_ar_ready;
    assign beat_acc  = axi_r_valid && r_ready_q;
    assign data_pop  = !data_empty && rd_data_ready;
    // A burst is only requested once the data FIFO can hold every beat of it.
    assign data_free = DCNT_W'(DATA_DEPTH) - data_count;
    assign data_need = DCNT_W'(cmd_head[CMD_W-1 -: 8]) + DCNT_W'(1);

    assign axi_ar_req_en    = ar_req_en_q;
    assign axi_ar_addr      = ar_addr_q;
    assign axi_ar_burst_len = ar_len_q;
    assign axi_r_ready      = r_ready_q;
    assign rd_data_valid    = !data_empty;
    assign rd_data_out      = data_empty ? '0 : data_head[AXI_DATA_WIDTH-1:0];
    assign rd_data_last     = !data_empty && data_head[AXI_DATA_WIDTH];
    assign err_rcmd_fifo    = err_rcmd_q;
    assign err_rdata_fifo   = err_rdata_q;
    assign err_rlast        = err_rlast_q;

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state_q     <= RD_IDLE;
            ar_req_en_q <= 1'b0;
            ar_addr_q   <= '0;
            ar_len_q    <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            r_ready_q   <= 1'b0;
            err_rcmd_q  <= 1'b0;
            err_rdata_q <= 1'b0;
            err_rlast_q <= 1'b0;
        end else begin
            err_rcmd_q  <= rd_req_en && cmd_full && !cmd_pop;
            err_rdata_q <= beat_acc && data_full && !data_pop;
            err_rlast_q <= 1'b0;
            case (state_q)
                RD_IDLE: begin
                    if (!cmd_empty && (data_free >= data_need)) begin
                        state_q     <= RD_REQ;
                        ar_req_en_q <= 1'b1;
                        ar_addr_q   <= cmd_head[AXI_ADDR_WIDTH-1:0];
                        ar_len_q    <= cmd_head[CMD_W-1 -: 8];
                    end
                end
                RD_REQ: begin
                    if (axi_ar_ready) begin
                        state_q     <= RD_DATA;
                        ar_req_en_q <= 1'b0;
                        ar_addr_q   <= '0;
                        ar_len_q    <= '0;
                        len_q       <= ar_len_q;
                        beat_cnt_q  <= '0;
                        r_ready_q   <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (beat_acc) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                        // Only r_last ends the burst; length mismatches are flagged.
                        if (axi_r_last) begin
                            err_rlast_q <= (beat_cnt_q != len_q);
                            state_q     <= RD_END;
                            r_ready_q   <= 1'b0;
                        end else begin
                            err_rlast_q <= (beat_cnt_q > len_q);
                        end
                    end
                end
                RD_END: begin
                    state_q <= RD_IDLE;
                end
                default: begin
                    state_q     <= RD_IDLE;
                    ar_req_en_q <= 1'b0;
                    r_ready_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rd_buffer.sv
// Scoreboard bench for rd_buffer: expected AR requests and user beats are queued
// by the stimulus and checked by a monitor whenever the DUT hands one over.
module tb_rd_buffer;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 128;

    logic          axi_clk;
    logic          axi_rst;
    logic          rd_req_en;
    logic [AW-1:0] rd_addr_in;
    logic [7:0]    rd_burst_len;
    logic          axi_ar_req_en;
    logic          axi_ar_ready;
    logic [AW-1:0] axi_ar_addr;
    logic [7:0]    axi_ar_burst_len;
    logic          axi_r_valid;
    logic          axi_r_ready;
    logic [DW-1:0] axi_r_data;
    logic          axi_r_last;
    logic [DW-1:0] rd_data_out;
    logic          rd_data_valid;
    logic          rd_data_last;
    logic          rd_data_ready;
    logic          err_rcmd_fifo;
    logic          err_rdata_fifo;
    logic          err_rlast;

    rd_buffer #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .CMD_DEPTH      (16),
        .DATA_DEPTH     (512)
    ) dut (
        .axi_clk          (axi_clk),
        .axi_rst          (axi_rst),
        .rd_req_en        (rd_req_en),
        .rd_addr_in       (rd_addr_in),
        .rd_burst_len     (rd_burst_len),
        .axi_ar_req_en    (axi_ar_req_en),
        .axi_ar_ready     (axi_ar_ready),
        .axi_ar_addr      (axi_ar_addr),
        .axi_ar_burst_len (axi_ar_burst_len),
        .axi_r_valid      (axi_r_valid),
        .axi_r_ready      (axi_r_ready),
        .axi_r_data       (axi_r_data),
        .axi_r_last       (axi_r_last),
        .rd_data_out      (rd_data_out),
        .rd_data_valid    (rd_data_valid),
        .rd_data_last     (rd_data_last),
        .rd_data_ready    (rd_data_ready),
        .err_rcmd_fifo    (err_rcmd_fifo),
        .err_rdata_fifo   (err_rdata_fifo),
        .err_rlast        (err_rlast)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    int vectors;
    int miscompares;
    int err_rcmd_n;
    int err_rdata_n;
    int err_rlast_n;
    int ar_hs_n;
    bit t6_done;
    logic [DW:0]   exp_q[$];
    logic [AW+7:0] ar_exp_q[$];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    // Samples on the falling edge, half a cycle clear of the DUT's active edge.
    task automatic monitor();
        forever begin
            @(negedge axi_clk);
            if (!axi_rst) begin
                if (rd_data_valid && rd_data_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_user_beat");
                    else chk("user_beat", {rd_data_last, rd_data_out}, exp_q.pop_front());
                end
                if (axi_ar_req_en && axi_ar_ready) begin
                    ar_hs_n++;
                    if (ar_exp_q.size() == 0) fail_now("unexpected_ar");
                    else chk("ar_req", {axi_ar_burst_len, axi_ar_addr}, ar_exp_q.pop_front());
                end
                if (err_rcmd_fifo)  err_rcmd_n++;
                if (err_rdata_fifo) err_rdata_n++;
                if (err_rlast)      err_rlast_n++;
            end
        end
    endtask

    task automatic issue(input logic [AW-1:0] addr, input logic [7:0] len, input bit expect_ar);
        rd_req_en    = 1'b1;
        rd_addr_in   = addr;
        rd_burst_len = len;
        if (expect_ar) ar_exp_q.push_back({len, addr});
        tick();
        rd_req_en = 1'b0;
    endtask

    // Slave side: presents beats base+i, each held until the DUT accepts it.
    task automatic send_beats(input int n, input int last_idx, input int base, input bit push);
        int guard;
        for (int i = 0; i < n; i++) begin
            axi_r_valid = 1'b1;
            axi_r_data  = DW'(base + i);
            axi_r_last  = (i == last_idx);
            guard = 0;
            while (!axi_r_ready && guard < 2000) begin
                tick();
                guard++;
            end
            if (guard >= 2000) begin
                fail_now("r_ready_timeout");
                break;
            end
            if (push) exp_q.push_back({axi_r_last, axi_r_data});
            tick();
        end
        axi_r_valid = 1'b0;
        axi_r_last  = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            tick();
            guard++;
        end
        if (guard >= 5000) fail_now("drain_timeout");
        repeat (2) tick();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ar"}, {axi_ar_req_en, axi_ar_burst_len, axi_ar_addr}, '0);
        chk({tag, "_flags"}, {axi_r_ready, rd_data_valid, rd_data_last}, '0);
        chk({tag, "_data"}, rd_data_out, '0);
        chk({tag, "_err"}, {err_rcmd_fifo, err_rdata_fifo, err_rlast}, '0);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s_cmd, s_data, s_last, h;
        vectors = 0; miscompares = 0;
        err_rcmd_n = 0; err_rdata_n = 0; err_rlast_n = 0; ar_hs_n = 0;
        t6_done = 1'b0;
        axi_rst = 1'b1; rd_req_en = 1'b0; rd_addr_in = '0; rd_burst_len = '0;
        axi_ar_ready = 1'b0; axi_r_valid = 1'b0; axi_r_data = '0; axi_r_last = 1'b0;
        rd_data_ready = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) tick();
        chk_outputs_zero("reset");
        axi_rst = 1'b0;
        tick();

        // Single len=3 burst: AR at the second edge, four beats, last on D3.
        s_cmd = err_rcmd_n; s_data = err_rdata_n; s_last = err_rlast_n;
        axi_ar_ready = 1'b1;
        issue(32'h1000, 8'd3, 1'b1);
        chk("ar_not_after_edge1", axi_ar_req_en, 1'b0);
        tick();
        chk("ar_at_edge2", {axi_ar_req_en, axi_ar_burst_len, axi_ar_addr}, {1'b1, 8'd3, 32'h1000});
        send_beats(4, 3, 'hD0, 1'b1);
        drain();
        chk("basic_errs", {32'(err_rcmd_n - s_cmd), 32'(err_rdata_n - s_data), 32'(err_rlast_n - s_last)}, '0);

        // Command FIFO overflow: 17 requests while AR is stalled.
        s_cmd = err_rcmd_n; h = ar_hs_n;
        axi_ar_ready = 1'b0;
        for (int i = 0; i < 17; i++) issue(32'h2000 + 32'(i * 256), 8'd0, i < 16);
        repeat (3) tick();
        chk("cmd_overflow_pulses", err_rcmd_n - s_cmd, 1);
        chk("ar_stalled_head", {axi_ar_req_en, axi_ar_addr}, {1'b1, 32'h2000});
        axi_ar_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_beats(1, 0, 'h2000 + i, 1'b1);
        drain();
        chk("queued_bursts_issued", ar_hs_n - h, 16);

        // Early last: len=7 with last on beat index 5.
        s_last = err_rlast_n;
        issue(32'h3000, 8'd7, 1'b1);
        send_beats(6, 5, 'h300, 1'b1);
        drain();
        chk("early_last_pulse", err_rlast_n - s_last, 1);
        chk("early_last_idle", {axi_r_ready, axi_ar_req_en}, 2'b00);

        // Backpressure: eight len=255 commands, user not accepting.
        s_cmd = err_rcmd_n; s_data = err_rdata_n; s_last = err_rlast_n; h = ar_hs_n;
        rd_data_ready = 1'b0;
        for (int i = 0; i < 8; i++) issue(32'h4000 + 32'(i * 'h1000), 8'd255, 1'b1);
        send_beats(256, 255, 'h10000, 1'b1);
        send_beats(256, 255, 'h20000, 1'b1);
        repeat (20) tick();
        chk("only_two_bursts", ar_hs_n - h, 2);
        chk("third_ar_withheld", axi_ar_req_en, 1'b0);
        rd_data_ready = 1'b1;
        repeat (255) tick();
        rd_data_ready = 1'b0;
        repeat (10) tick();
        chk("withheld_at_255_free", {axi_ar_req_en, 32'(ar_hs_n - h)}, {1'b0, 32'd2});
        rd_data_ready = 1'b1;
        repeat (3) tick();
        chk("third_ar_at_256_free", ar_hs_n - h, 3);
        for (int b = 2; b < 8; b++) send_beats(256, 255, 'h10000 * (b + 1), 1'b1);
        drain();
        chk("backpressure_errs", {32'(err_rcmd_n - s_cmd), 32'(err_rdata_n - s_data), 32'(err_rlast_n - s_last)}, '0);

        // Reset in the middle of a len=7 burst after three beats.
        s_cmd = err_rcmd_n; s_data = err_rdata_n; s_last = err_rlast_n;
        rd_data_ready = 1'b0;
        issue(32'h5000, 8'd7, 1'b1);
        send_beats(3, 7, 'h500, 1'b0);
        chk("pre_reset_buffered", {rd_data_valid, axi_r_ready}, 2'b11);
        axi_r_valid = 1'b1; axi_r_data = DW'('h5FF); axi_rst = 1'b1;
        tick();
        chk_outputs_zero("mid_reset");
        axi_rst = 1'b0; rd_data_ready = 1'b1;
        repeat (5) tick();
        chk("post_reset_no_stale", {rd_data_valid, axi_r_ready, axi_ar_req_en}, 3'b000);
        axi_r_valid = 1'b0;
        issue(32'h6000, 8'd1, 1'b1);
        send_beats(2, 1, 'h600, 1'b1);
        drain();
        chk("post_reset_errs", {32'(err_rcmd_n - s_cmd), 32'(err_rdata_n - s_data), 32'(err_rlast_n - s_last)}, '0);

        // User ready toggling during a len=15 burst with back-to-back beats.
        s_data = err_rdata_n; s_last = err_rlast_n;
        issue(32'h7000, 8'd15, 1'b1);
        fork
            begin
                send_beats(16, 15, 'h700, 1'b1);
                t6_done = 1'b1;
            end
            begin
                while (!t6_done) begin
                    tick();
                    rd_data_ready = ~rd_data_ready;
                end
            end
        join
        rd_data_ready = 1'b1;
        drain();
        chk("toggle_errs", {32'(err_rdata_n - s_data), 32'(err_rlast_n - s_last)}, '0);
        chk("ar_queue_empty", ar_exp_q.size(), 0);
        chk("data_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
